gray_filter_frame_ctrl: RTL

GRAY_FILTER_FRAME_CTRL -- requirements
Module: gray_filter_frame_ctrl

---
 rtl/gray_filter_pkg.sv | 21 ++
 rtl/gray_filter_frame_ctrl_size_checker.sv | 83 ++++++++
 rtl/gray_filter_frame_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/gray_filter_pkg.sv
// ---------------------------------------------------------------------------
// gray_filter_pkg
// Definitions shared by the gray filter frame controller and its sub-module:
//   - state_t        : frame controller FSM states (IDLE, ACTIVE, DRAIN)
//   - PIX_W          : gray pixel width in bits
//   - DEF_IMG_HDISP  : default active pixels per line
//   - DEF_IMG_VDISP  : default active lines per frame
// ---------------------------------------------------------------------------
package gray_filter_pkg;

    localparam int PIX_W         = 8;
    localparam int DEF_IMG_HDISP = 640;
    localparam int DEF_IMG_VDISP = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/gray_filter_frame_ctrl_size_checker.sv
// ---------------------------------------------------------------------------
// frame_size_checker
// Counts pixels per line and lines per frame on the source stream and flags
// a frame whose geometry differs from IMG_HDISP x IMG_VDISP. Only built when
// the FRAME_CHECK_EN macro is defined.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   pre_gray_valid  : source line valid
//   pre_gray_clken  : source pixel enable
//   frame_start     : source vsync rising edge that starts a frame
//   frame_end       : source vsync falling edge of a frame in progress
//   frame_err       : one-cycle pulse at frame_end if any mismatch was seen
// ---------------------------------------------------------------------------
module frame_size_checker
    import gray_filter_pkg::*;
#(
    parameter int IMG_HDISP = DEF_IMG_HDISP,
    parameter int IMG_VDISP = DEF_IMG_VDISP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pre_gray_valid,
    input  logic pre_gray_clken,
    input  logic frame_start,
    input  logic frame_end,
    output logic frame_err
);

    localparam int PW = $clog2(IMG_HDISP) + 1;
    localparam int LW = $clog2(IMG_VDISP) + 1;

    logic [PW-1:0] pix_cnt_reg;
    logic [LW-1:0] line_cnt_reg;
    logic          valid_d_reg;
    logic          err_flag_reg;

    logic          valid_fall;
    logic          pix_mismatch;
    logic [LW-1:0] line_eff;
    logic          line_mismatch;

    assign valid_fall   = valid_d_reg & ~pre_gray_valid;
    assign pix_mismatch = (pix_cnt_reg != PW'(IMG_HDISP));

    // A line may end on the same cycle the frame ends, so the line count used
    // for the end-of-frame comparison includes that pending increment.
    assign line_eff      = (valid_fall && (line_cnt_reg != '1)) ? line_cnt_reg + LW'(1)
                                                                : line_cnt_reg;
    assign line_mismatch = (line_eff != LW'(IMG_VDISP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_reg  <= '0;
            line_cnt_reg <= '0;
            valid_d_reg  <= 1'b0;
            err_flag_reg <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            valid_d_reg <= pre_gray_valid;

            if (valid_fall)
                pix_cnt_reg <= '0;
            else if (pre_gray_valid && pre_gray_clken && (pix_cnt_reg != '1))
                pix_cnt_reg <= pix_cnt_reg + PW'(1);

            if (frame_start)
                line_cnt_reg <= '0;
            else if (valid_fall && (line_cnt_reg != '1))
                line_cnt_reg <= line_cnt_reg + LW'(1);

            // Sticky per-frame error; reported once at frame end.
            if (frame_start || frame_end)
                err_flag_reg <= 1'b0;
            else if (valid_fall && pix_mismatch)
                err_flag_reg <= 1'b1;

            frame_err <= frame_end &&
                         (err_flag_reg || (valid_fall && pix_mismatch) || line_mismatch);
        end
    end

endmodule

// File: rtl/gray_filter_frame_ctrl.sv
// ---------------------------------------------------------------------------
// gray_filter_frame_ctrl
// Routes a gray video stream either through an external median filter or
// straight to the output. The mode is sampled only at a frame start so a
// frame is never split between the two paths.
//
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   cfg_filter_en                  : requested mode (1 filter, 0 bypass)
//   pre_gray_vsync/valid/clken/data: source stream
//   flt_vsync/valid/clken/data     : stream sent to the filter (1 cycle late)
//   flt_post_vsync/valid/clken/data: stream returned by the filter
//   post_gray_vsync/valid/clken    : selected output stream (registered)
//   post_pixel_data                : selected output pixel, 0 when not valid
//   mode_active                    : mode of the current output frame
//   frame_done                     : pulse when post_gray_vsync falls
//   frame_err                      : pulse on source frame-size mismatch
//
// Build option: define FRAME_CHECK_EN to include frame_size_checker;
// otherwise frame_err is tied low.
// ---------------------------------------------------------------------------
module gray_filter_frame_ctrl
    import gray_filter_pkg::*;
#(
    parameter int IMG_HDISP = DEF_IMG_HDISP,
    parameter int IMG_VDISP = DEF_IMG_VDISP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_filter_en,
    input  logic             pre_gray_vsync,
    input  logic             pre_gray_valid,
    input  logic             pre_gray_clken,
    input  logic [PIX_W-1:0] pre_gray_data,
    output logic             flt_vsync,
    output logic             flt_valid,
    output logic             flt_clken,
    output logic [PIX_W-1:0] flt_data,
    input  logic             flt_post_vsync,
    input  logic             flt_post_valid,
    input  logic             flt_post_clken,
    input  logic [PIX_W-1:0] flt_post_data,
    output logic             post_gray_vsync,
    output logic             post_gray_valid,
    output logic             post_gray_clken,
    output logic [PIX_W-1:0] post_pixel_data,
    output logic             mode_active,
    output logic             frame_done,
    output logic             frame_err
);

    state_t state_reg;
    logic   mode_reg;
    logic   src_vs_d_reg;
    logic   flt_post_vs_d_reg;

    logic             vs_rise;
    logic             vs_fall;
    logic             flt_post_vs_fall;
    logic             mode_next;
    logic             path_en;
    logic             path_filt;
    logic             sel_vsync;
    logic             sel_valid;
    logic             sel_clken;
    logic [PIX_W-1:0] sel_data;

    assign vs_rise          = pre_gray_vsync & ~src_vs_d_reg;
    assign vs_fall          = ~pre_gray_vsync & src_vs_d_reg;
    assign flt_post_vs_fall = ~flt_post_vsync & flt_post_vs_d_reg;

    // While the filter is still draining the previous frame its output path is
    // busy, so a frame starting then must keep the previous mode.
    assign mode_next = (state_reg == DRAIN) ? mode_reg : cfg_filter_en;

    // The path decision for the start cycle uses the mode about to be latched,
    // so the first registered output of a frame already comes from the right
    // source. Outside a frame nothing is forwarded.
    assign path_en   = vs_rise | (state_reg != IDLE);
    assign path_filt = vs_rise ? mode_next : ((state_reg != IDLE) & mode_reg);

    always_comb begin
        sel_vsync = 1'b0;
        sel_valid = 1'b0;
        sel_clken = 1'b0;
        sel_data  = '0;
        if (path_en) begin
            if (path_filt) begin
                sel_vsync = flt_post_vsync;
                sel_valid = flt_post_valid;
                sel_clken = flt_post_clken;
                sel_data  = flt_post_data;
            end else begin
                sel_vsync = pre_gray_vsync;
                sel_valid = pre_gray_valid;
                sel_clken = pre_gray_clken;
                sel_data  = pre_gray_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            mode_reg          <= 1'b0;
            // Treat vsync as already high so a frame in progress at reset
            // release is not mistaken for a new frame start.
            src_vs_d_reg      <= 1'b1;
            flt_post_vs_d_reg <= 1'b0;
            flt_vsync         <= 1'b0;
            flt_valid         <= 1'b0;
            flt_clken         <= 1'b0;
            flt_data          <= '0;
            post_gray_vsync   <= 1'b0;
            post_gray_valid   <= 1'b0;
            post_gray_clken   <= 1'b0;
            post_pixel_data   <= '0;
            mode_active       <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            src_vs_d_reg      <= pre_gray_vsync;
            flt_post_vs_d_reg <= flt_post_vsync;

            case (state_reg)
                IDLE: begin
                    if (vs_rise) begin
                        state_reg <= ACTIVE;
                        mode_reg  <= mode_next;
                    end
                end
                ACTIVE: begin
                    if (vs_fall)
                        state_reg <= mode_reg ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (vs_rise) begin
                        state_reg <= ACTIVE;
                        mode_reg  <= mode_next;
                    end else if (flt_post_vs_fall) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (path_filt) begin
                flt_vsync <= pre_gray_vsync;
                flt_valid <= pre_gray_valid;
                flt_clken <= pre_gray_clken;
                flt_data  <= pre_gray_data;
            end else begin
                flt_vsync <= 1'b0;
                flt_valid <= 1'b0;
                flt_clken <= 1'b0;
                flt_data  <= '0;
            end

            post_gray_vsync <= sel_vsync;
            post_gray_valid <= sel_valid;
            post_gray_clken <= sel_clken;
            post_pixel_data <= sel_valid ? sel_data : '0;

            if (sel_vsync && !post_gray_vsync)
                mode_active <= path_filt;

            frame_done <= post_gray_vsync & ~sel_vsync;
        end
    end

`ifdef FRAME_CHECK_EN
    logic frame_start;
    logic frame_end;

    assign frame_start = vs_rise;
    assign frame_end   = vs_fall & (state_reg == ACTIVE);

    frame_size_checker #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_size_checker (
        .clk            (clk),
        .rst_n          (rst_n),
        .pre_gray_valid (pre_gray_valid),
        .pre_gray_clken (pre_gray_clken),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .frame_err      (frame_err)
    );
`else
    assign frame_err = 1'b0;
`endif

endmodule
